// File: rtl/ct_clint_pkg.sv
// Shared definitions for the CLINT APB requester arbiter: FSM encoding, privilege codes, CLINT map.
// Pure declarations; no timing or flow-control behaviour of its own.
package ct_clint_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SETUP  = 2'b01,
      ST_ACCESS = 2'b10
   } apb_state_t;

   localparam logic [1:0] PROT_U = 2'b00;
   localparam logic [1:0] PROT_S = 2'b01;
   localparam logic [1:0] PROT_M = 2'b11;

   localparam logic [31:0] CLINT_MSIP_BASE     = 32'h0000_0000;
   localparam logic [31:0] CLINT_MTIMECMP_BASE = 32'h0000_4000;
   localparam logic [31:0] CLINT_MTIME         = 32'h0000_BFF8;
   localparam logic [31:0] CLINT_SIZE          = 32'h0001_0000;

   // Read data is only meaningful for a clean read; errors and writes return zero.
   function automatic logic [31:0] apb_rsp_data(input logic        err,
                                                input logic        wr,
                                                input logic [31:0] rdata);
      return (err || wr) ? 32'h0 : rdata;
   endfunction

endpackage

// File: rtl/ct_clint_rr_arb.sv
// Round-robin picker: first eligible index at or after ptr, wrapping; one-hot grant plus index.
// Purely combinational, zero latency; no flow control.
module ct_clint_rr_arb
   import ct_clint_pkg::*;
#(
   parameter int REQ_NUM = 2,
   parameter int IDX_W   = 1
) (
   input  logic [REQ_NUM-1:0] eligible,
   input  logic [IDX_W-1:0]   ptr,
   output logic [REQ_NUM-1:0] grant,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   localparam logic [IDX_W:0] N_W = (IDX_W+1)'(REQ_NUM);

   logic [IDX_W:0]   cand_w;
   logic [IDX_W-1:0] cand;

   always_comb begin
      grant  = '0;
      idx    = '0;
      any    = 1'b0;
      cand_w = '0;
      cand   = '0;
      for (int k = 0; k < REQ_NUM; k++) begin
         // ptr + k never exceeds 2*REQ_NUM-2, so one conditional subtract wraps it
         cand_w = {1'b0, ptr} + (IDX_W+1)'(k);
         if (cand_w >= N_W) begin
            cand_w = cand_w - N_W;
         end
         cand = cand_w[IDX_W-1:0];
         if (!any && eligible[cand]) begin
            any         = 1'b1;
            idx         = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ct_clint_apb_arb.sv
// Shares the CLINT APB slave among REQ_NUM requesters, round-robin, one SETUP/ACCESS transfer at a time.
// Grant->rsp_done is 3 cycles with zero wait states; requesters hold until rsp_done; hung slaves time out.
module ct_clint_apb_arb
   import ct_clint_pkg::*;
#(
   parameter int REQ_NUM = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                  forever_apbclk,
   input  logic                  cpurst,
   input  logic [REQ_NUM-1:0]    req_valid,
   input  logic [32*REQ_NUM-1:0] req_addr,
   input  logic [REQ_NUM-1:0]    req_write,
   input  logic [32*REQ_NUM-1:0] req_wdata,
   input  logic [2*REQ_NUM-1:0]  req_prot,
   output logic [REQ_NUM-1:0]    rsp_done,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic                  psel_clint,
   output logic                  penable,
   output logic [31:0]           paddr,
   output logic                  pwrite,
   output logic [31:0]           pwdata,
   output logic [1:0]            pprot,
   input  logic [31:0]           prdata_clint,
   input  logic                  pready_clint,
   input  logic                  perr_clint
);

   localparam int IDX_W = $clog2(REQ_NUM);
   localparam int TMR_W = $clog2(TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(REQ_NUM - 1);

   apb_state_t       state, state_nxt;
   logic [IDX_W-1:0] owner, owner_nxt;
   logic [IDX_W-1:0] ptr, ptr_nxt;
   logic [TMR_W-1:0] timer, timer_nxt;

   logic               psel_nxt, penable_nxt, pwrite_nxt, err_nxt;
   logic [31:0]        paddr_nxt, pwdata_nxt, rdata_nxt;
   logic [1:0]         pprot_nxt;
   logic [REQ_NUM-1:0] done_nxt;

   logic [REQ_NUM-1:0] eligible, grant;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_any;

   logic [31:0] sel_addr, sel_wdata;
   logic        sel_write;
   logic [1:0]  sel_prot;

   // A requester whose completion is being signalled this cycle is not yet allowed to re-request
   assign eligible = req_valid & ~rsp_done;

   ct_clint_rr_arb #(
      .REQ_NUM (REQ_NUM),
      .IDX_W   (IDX_W)
   ) u_rr_arb (
      .eligible (eligible),
      .ptr      (ptr),
      .grant    (grant),
      .idx      (gnt_idx),
      .any      (gnt_any)
   );

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_write = 1'b0;
      sel_prot  = '0;
      for (int i = 0; i < REQ_NUM; i++) begin
         if (grant[i]) begin
            sel_addr  = req_addr[32*i +: 32];
            sel_wdata = req_wdata[32*i +: 32];
            sel_write = req_write[i];
            sel_prot  = req_prot[2*i +: 2];
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      owner_nxt   = owner;
      ptr_nxt     = ptr;
      timer_nxt   = timer;
      psel_nxt    = psel_clint;
      penable_nxt = penable;
      paddr_nxt   = paddr;
      pwrite_nxt  = pwrite;
      pwdata_nxt  = pwdata;
      pprot_nxt   = pprot;
      done_nxt    = '0;
      err_nxt     = 1'b0;
      rdata_nxt   = '0;

      unique case (state)
         ST_IDLE: begin
            if (gnt_any) begin
               state_nxt   = ST_SETUP;
               owner_nxt   = gnt_idx;
               ptr_nxt     = (gnt_idx == IDX_LAST) ? '0 : gnt_idx + 1'b1;
               psel_nxt    = 1'b1;
               penable_nxt = 1'b0;
               paddr_nxt   = sel_addr;
               pwrite_nxt  = sel_write;
               pwdata_nxt  = sel_wdata;
               pprot_nxt   = sel_prot;
            end
         end
         ST_SETUP: begin
            state_nxt   = ST_ACCESS;
            penable_nxt = 1'b1;
            timer_nxt   = '0;
         end
         ST_ACCESS: begin
            if (pready_clint) begin
               state_nxt       = ST_IDLE;
               psel_nxt        = 1'b0;
               penable_nxt     = 1'b0;
               done_nxt[owner] = 1'b1;
               err_nxt         = perr_clint;
               rdata_nxt       = apb_rsp_data(perr_clint, pwrite, prdata_clint);
            end else if (timer == TMR_LAST) begin
               // slave never answered: close the transfer ourselves and report an error
               state_nxt       = ST_IDLE;
               psel_nxt        = 1'b0;
               penable_nxt     = 1'b0;
               done_nxt[owner] = 1'b1;
               err_nxt         = 1'b1;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         default: begin
            state_nxt   = ST_IDLE;
            psel_nxt    = 1'b0;
            penable_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge forever_apbclk) begin
      if (cpurst) begin
         state      <= ST_IDLE;
         owner      <= '0;
         ptr        <= '0;
         timer      <= '0;
         psel_clint <= 1'b0;
         penable    <= 1'b0;
         paddr      <= '0;
         pwrite     <= 1'b0;
         pwdata     <= '0;
         pprot      <= '0;
         rsp_done   <= '0;
         rsp_err    <= 1'b0;
         rsp_rdata  <= '0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         ptr        <= ptr_nxt;
         timer      <= timer_nxt;
         psel_clint <= psel_nxt;
         penable    <= penable_nxt;
         paddr      <= paddr_nxt;
         pwrite     <= pwrite_nxt;
         pwdata     <= pwdata_nxt;
         pprot      <= pprot_nxt;
         rsp_done   <= done_nxt;
         rsp_err    <= err_nxt;
         rsp_rdata  <= rdata_nxt;
      end
   end

endmodule
